// File: rtl/frame_buffer_writer_if.sv
// Pixel stream and frame buffer write port bundle for frame_buffer_writer.
// slave: the writer. master: upstream pixel source plus reader acknowledge.
// DATA_WIDTH/ADDR_WIDTH must match the parameters of the attached writer.
interface frame_buffer_writer_if #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_sof;
    logic                  s_eol;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wAddr;
    logic [DATA_WIDTH-1:0] wData;
    logic                  frame_done;
    logic                  frame_valid;
    logic                  frame_ack;
    logic                  busy;
    logic                  err_sync;
    logic [7:0]            frame_count;

    modport slave (
        input  s_valid, s_data, s_sof, s_eol, frame_ack,
        output s_ready, we, wAddr, wData, frame_done, frame_valid, busy, err_sync, frame_count
    );

    modport master (
        output s_valid, s_data, s_sof, s_eol, frame_ack,
        input  s_ready, we, wAddr, wData, frame_done, frame_valid, busy, err_sync, frame_count
    );
endinterface

// File: rtl/frame_buffer_writer.sv
// Frame buffer write-side producer. Turns a raster pixel stream (sof/eol markers)
// into registered write strobe/address/data, then blocks input until the reader
// acknowledges the completed frame.
// Optional: define FBW_SYNC_CHECK_EN to check sof/eol markers while writing.
module frame_buffer_writer #(
    parameter int unsigned DATA_WIDTH   = 24,
    parameter int unsigned IMG_WIDTH    = 176,
    parameter int unsigned IMG_HEIGHT   = 240,
    parameter int unsigned TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
    parameter int unsigned ADDR_WIDTH   = $clog2(TOTAL_PIXELS)
) (
    input logic                  clk,
    input logic                  reset,
    frame_buffer_writer_if.slave bus
);
    localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(TOTAL_PIXELS - 1);
    localparam logic [ColW-1:0]       LastCol  = ColW'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ColW-1:0]       col_q, col_d;
    logic [RowW-1:0]       row_q, row_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  fvalid_q, fvalid_d;
    logic                  err_q, err_d;
    logic [7:0]            count_q, count_d;

    logic                  accept;
    logic                  do_write;
    logic                  restart;
    logic                  sync_err;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ColW-1:0]       cur_col;
    logic [RowW-1:0]       cur_row;

    assign accept = bus.s_valid && (state_q != StHold);

`ifndef FBW_SYNC_CHECK_EN
    // eol only matters when marker checking is built in
    logic unused_eol;
    assign unused_eol = bus.s_eol;
`endif

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            fvalid_q <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            col_q    <= col_d;
            row_q    <= row_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            fvalid_q <= fvalid_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    // Next-state: decode what to do with an accepted pixel, then apply the write.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        col_d    = col_q;
        row_d    = row_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        fvalid_d = fvalid_q;
        err_d    = err_q;
        count_d  = count_q;
        do_write = 1'b0;
        restart  = 1'b0;
        sync_err = 1'b0;

        case (state_q)
            StIdle: begin
                // Pixels before a start-of-frame are discarded.
                if (accept && bus.s_sof) begin
                    do_write = 1'b1;
                    restart  = 1'b1;
                end
            end
            StWrite: begin
                if (accept) begin
`ifdef FBW_SYNC_CHECK_EN
                    if (bus.s_sof) begin
                        do_write = 1'b1;
                        restart  = 1'b1;
                        err_d    = 1'b1;
                    end else if (bus.s_eol != (col_q == LastCol)) begin
                        sync_err = 1'b1;
                    end else begin
                        do_write = 1'b1;
                    end
`else
                    do_write = 1'b1;
`endif
                end
            end
            StHold: begin
                if (bus.frame_ack) begin
                    fvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        cur_addr = restart ? '0 : addr_q;
        cur_col  = restart ? '0 : col_q;
        cur_row  = restart ? '0 : row_q;

        if (do_write) begin
            we_d    = 1'b1;
            waddr_d = cur_addr;
            wdata_d = bus.s_data;
            if (cur_addr == LastAddr) begin
                done_d   = 1'b1;
                fvalid_d = 1'b1;
                count_d  = count_q + 8'd1;
                state_d  = StHold;
                addr_d   = '0;
                col_d    = '0;
                row_d    = '0;
            end else begin
                state_d = StWrite;
                addr_d  = cur_addr + 1'b1;
                if (cur_col == LastCol) begin
                    col_d = '0;
                    row_d = cur_row + 1'b1;
                end else begin
                    col_d = cur_col + 1'b1;
                    row_d = cur_row;
                end
            end
        end

        if (sync_err) begin
            err_d   = 1'b1;
            state_d = StIdle;
        end
    end

    assign bus.s_ready     = (state_q != StHold);
    assign bus.we          = we_q;
    assign bus.wAddr       = waddr_q;
    assign bus.wData       = wdata_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_valid = fvalid_q;
    // Covers the final write too, which appears after the move to hold.
    assign bus.busy        = (state_q == StWrite) || done_q;
    assign bus.err_sync    = err_q;
    assign bus.frame_count = count_q;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer on a 4x2 image.
module tb_frame_buffer_writer;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int TOTAL = IMG_W * IMG_H;
`ifdef FBW_SYNC_CHECK_EN
    localparam bit SyncEn = 1'b1;
`else
    localparam bit SyncEn = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    frame_buffer_writer_if #(.DATA_WIDTH(24), .ADDR_WIDTH(3)) bus ();

    frame_buffer_writer #(
        .DATA_WIDTH(24),
        .IMG_WIDTH (IMG_W),
        .IMG_HEIGHT(IMG_H)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 writing, 2 holding; m_pix = pixels written so far.
    int          m_mode;
    int          m_pix;
    logic        m_we, m_done, m_fvalid, m_busy, m_err;
    logic [2:0]  m_addr;
    logic [23:0] m_data;
    int          m_count;

    typedef struct {
        logic        v, sof, eol, ack;
        logic [23:0] data;
        logic        e_ready, e_we;
        logic [2:0]  e_addr;
        logic [23:0] e_data;
        logic        e_done, e_fvalid;
        logic [7:0]  e_count;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pix = 0; m_we = 0; m_done = 0; m_fvalid = 0; m_busy = 0;
        m_err = 0; m_addr = 0; m_data = 0; m_count = 0;
    endtask

    task automatic model_update(input logic v, sof, eol, ack, input logic [23:0] d);
        bit wr;
        int wa;
        wr = 0; wa = 0; m_we = 0; m_done = 0;
        if (m_mode == 2) begin
            if (ack) begin m_fvalid = 0; m_mode = 0; end
        end else if (v) begin
            if (m_mode == 0) begin
                if (sof) begin wr = 1; wa = 0; end
            end else if (SyncEn && sof) begin
                wr = 1; wa = 0; m_err = 1;
            end else if (SyncEn && (eol != ((m_pix % IMG_W) == IMG_W - 1))) begin
                m_err = 1; m_mode = 0;
            end else begin
                wr = 1; wa = m_pix;
            end
        end
        if (wr) begin
            m_we = 1; m_addr = 3'(wa); m_data = d; m_pix = wa + 1; m_mode = 1;
            if (m_pix == TOTAL) begin
                m_done = 1; m_fvalid = 1; m_count = (m_count + 1) % 256; m_mode = 2; m_pix = 0;
            end
        end
        m_busy = (m_mode == 1) || m_done;
    endtask

    // Drive one cycle at the negedge, check against the model at the next negedge.
    task automatic step(input logic v, sof, eol, ack, input logic [23:0] d);
        bus.s_valid = v; bus.s_sof = sof; bus.s_eol = eol; bus.frame_ack = ack; bus.s_data = d;
        #1;
        chk("s_ready", 32'(bus.s_ready), 32'(m_mode != 2));
        model_update(v, sof, eol, ack, d);
        @(negedge clk);
        chk("we", 32'(bus.we), 32'(m_we));
        chk("wAddr", 32'(bus.wAddr), 32'(m_addr));
        chk("wData", 32'(bus.wData), 32'(m_data));
        chk("frame_done", 32'(bus.frame_done), 32'(m_done));
        chk("frame_valid", 32'(bus.frame_valid), 32'(m_fvalid));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("err_sync", 32'(bus.err_sync), 32'(m_err));
        chk("frame_count", 32'(bus.frame_count), 32'(m_count));
    endtask

    function automatic logic eol_for(input int pix);
        return (pix % IMG_W) == IMG_W - 1;
    endfunction

    initial begin
        logic [23:0] d;
        int n;
        checks = 0;
        errors = 0;
        bus.s_valid = 0; bus.s_sof = 0; bus.s_eol = 0; bus.frame_ack = 0; bus.s_data = '0;

        // Clean frame with s_valid held high, then HOLD and acknowledge.
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{v:1, sof:(i == 0), eol:eol_for(i), ack:0, data:24'h100000 + 24'(i),
                       e_ready:1, e_we:1, e_addr:3'(i), e_data:24'h100000 + 24'(i),
                       e_done:(i == 7), e_fvalid:(i == 7), e_count:(i == 7) ? 8'd1 : 8'd0};
        end
        tbl[8]  = '{v:1, sof:0, eol:0, ack:0, data:24'hABCDEF, e_ready:0, e_we:0, e_addr:3'd7,
                    e_data:24'h100007, e_done:0, e_fvalid:1, e_count:8'd1};
        tbl[9]  = '{v:0, sof:0, eol:0, ack:1, data:24'h0, e_ready:0, e_we:0, e_addr:3'd7,
                    e_data:24'h100007, e_done:0, e_fvalid:0, e_count:8'd1};
        tbl[10] = '{v:0, sof:0, eol:0, ack:0, data:24'h0, e_ready:1, e_we:0, e_addr:3'd7,
                    e_data:24'h100007, e_done:0, e_fvalid:0, e_count:8'd1};

        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_we", 32'(bus.we), 0);
        chk("reset_wAddr", 32'(bus.wAddr), 0);
        chk("reset_wData", 32'(bus.wData), 0);
        chk("reset_frame_valid", 32'(bus.frame_valid), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_count", 32'(bus.frame_count), 0);
        chk("reset_ready", 32'(bus.s_ready), 1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            bus.s_valid = tbl[i].v; bus.s_sof = tbl[i].sof; bus.s_eol = tbl[i].eol;
            bus.frame_ack = tbl[i].ack; bus.s_data = tbl[i].data;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(bus.s_ready), 32'(tbl[i].e_ready));
            step(tbl[i].v, tbl[i].sof, tbl[i].eol, tbl[i].ack, tbl[i].data);
            chk($sformatf("tbl%0d_we", i), 32'(bus.we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_addr", i), 32'(bus.wAddr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_data", i), 32'(bus.wData), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_done", i), 32'(bus.frame_done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_fvalid", i), 32'(bus.frame_valid), 32'(tbl[i].e_fvalid));
            chk($sformatf("tbl%0d_count", i), 32'(bus.frame_count), 32'(tbl[i].e_count));
        end

        // Pixels before sof are dropped; the sof pixel lands at address 0.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 24'($urandom));
        d = 24'($urandom);
        step(1, 1, 0, 0, d);
        chk("sof_first_we", 32'(bus.we), 1);
        chk("sof_first_addr", 32'(bus.wAddr), 0);
        chk("sof_first_data", 32'(bus.wData), 32'(d));

        // Remainder of the frame with random valid gaps.
        n = 0;
        while (m_mode != 2 && n < 200) begin
            step(logic'($urandom_range(0, 2) != 0), 0, eol_for(m_pix), 0, 24'($urandom));
            n++;
        end
        chk("gap_frame_done_in_budget", 32'(m_mode), 2);

        // HOLD ignores input for 10 cycles, then acknowledge.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 24'($urandom));
        step(0, 0, 0, 1, 24'h0);
        #1;
        chk("ack_ready", 32'(bus.s_ready), 1);
        chk("ack_fvalid", 32'(bus.frame_valid), 0);
        d = 24'($urandom);
        step(1, 1, 0, 0, d);
        chk("after_ack_addr", 32'(bus.wAddr), 0);
        chk("after_ack_data", 32'(bus.wData), 32'(d));

        // Premature eol at col 2 (sof pixel above was col 0).
        step(1, 0, 0, 0, 24'($urandom));
        step(1, 0, 1, 0, 24'($urandom));
        for (int i = 0; i < TOTAL; i++) step(1, (i == 0), eol_for(i), 0, 24'($urandom));
        step(0, 0, 0, 1, 24'h0);
        step(0, 0, 0, 1, 24'h0);

        // Reset with wAddr=5 mid-frame.
        step(1, 1, 0, 0, 24'($urandom));
        for (int i = 1; i < 6; i++) step(1, 0, eol_for(i), 0, 24'($urandom));
        chk("pre_reset_addr", 32'(bus.wAddr), 5);
        reset = 1'b1;
        #1;
        chk("midrst_we", 32'(bus.we), 0);
        chk("midrst_wAddr", 32'(bus.wAddr), 0);
        chk("midrst_wData", 32'(bus.wData), 0);
        chk("midrst_done", 32'(bus.frame_done), 0);
        chk("midrst_fvalid", 32'(bus.frame_valid), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_err", 32'(bus.err_sync), 0);
        chk("midrst_count", 32'(bus.frame_count), 0);
        chk("midrst_ready", 32'(bus.s_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 24'h0);

        // Random traffic with occasional stray sof and wrong eol.
        for (int c = 0; c < 800; c++) begin
            logic v, s, e, a;
            v = ($urandom_range(0, 3) != 0);
            if (m_mode == 0) s = ($urandom_range(0, 2) == 0);
            else s = ($urandom_range(0, 59) == 0);
            e = eol_for(m_pix);
            if ($urandom_range(0, 39) == 0) e = ~e;
            a = ($urandom_range(0, 3) == 0);
            step(v, s, e, a, 24'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
